// File: rtl/door_lock_controller.sv
// Sequencer for the door-lock password check: fetch key, fetch lock, compare, then unlock or count a failure.
// Optional macro DOOR_LOCK_SENSOR_EN adds doorOpen so an opened-then-closed door ends UNLOCK early.
module door_lock_controller #(
    parameter int WIDTH          = 32,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             keyReq,
    input  logic [WIDTH-1:0] keyPass,
    input  logic             keyValid,
    input  logic [WIDTH-1:0] lockPass,
    input  logic             lockValid,
`ifdef DOOR_LOCK_SENSOR_EN
    input  logic             doorOpen,
`endif
    output logic             readKey,
    output logic             readLock,
    output logic             unlockDoor,
    output logic             alarm,
    output logic             locked,
    output logic             timeoutErr,
    output logic [3:0]       failCount,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_KEY  = 3'd1,
        READ_LOCK = 3'd2,
        COMPARE   = 3'd3,
        UNLOCK    = 3'd4,
        FAIL      = 3'd5,
        LOCKOUT   = 3'd6
    } state_t;

    // One shared timer serves the handshake wait, the unlock window and the lockout window.
    localparam int MAXA = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int MAXT = (MAXA > TIMEOUT_CYCLES) ? MAXA : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(MAXT + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] UN_LAST = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LO_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    FAIL_LIM = 4'(MAX_FAILS);

    state_t           cur, nxt;
    logic [TW-1:0]    tmr;
    logic [WIDTH-1:0] keyCap, lockCap;
    logic [3:0]       failCnt, failNxt;
    logic             toErr, toErrNxt;
    logic             doorExit;

`ifdef DOOR_LOCK_SENSOR_EN
    logic doorSeen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       doorSeen <= 1'b0;
        else if (cur != UNLOCK)        doorSeen <= 1'b0;
        else if (doorOpen)             doorSeen <= 1'b1;
    end

    assign doorExit = doorSeen && !doorOpen;
`else
    assign doorExit = 1'b0;
`endif

    always_comb begin
        nxt      = cur;
        failNxt  = failCnt;
        toErrNxt = 1'b0;
        case (cur)
            IDLE: if (keyReq) nxt = READ_KEY;
            // A valid on the last wait cycle wins over the timeout.
            READ_KEY: begin
                if (keyValid) nxt = READ_LOCK;
                else if (tmr == TO_LAST) begin
                    nxt      = IDLE;
                    toErrNxt = 1'b1;
                end
            end
            READ_LOCK: begin
                if (lockValid) nxt = COMPARE;
                else if (tmr == TO_LAST) begin
                    nxt      = IDLE;
                    toErrNxt = 1'b1;
                end
            end
            COMPARE: begin
                if (keyCap == lockCap) begin
                    failNxt = 4'd0;
                    nxt     = UNLOCK;
                end else begin
                    failNxt = (failCnt == 4'hF) ? failCnt : failCnt + 4'd1;
                    nxt     = FAIL;
                end
            end
            UNLOCK:  if (tmr == UN_LAST || doorExit) nxt = IDLE;
            FAIL:    nxt = (failCnt >= FAIL_LIM) ? LOCKOUT : IDLE;
            LOCKOUT: begin
                if (tmr == LO_LAST) begin
                    nxt     = IDLE;
                    failNxt = 4'd0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            tmr     <= '0;
            keyCap  <= '0;
            lockCap <= '0;
            failCnt <= 4'd0;
            toErr   <= 1'b0;
        end else begin
            cur     <= nxt;
            tmr     <= (nxt != cur || cur == IDLE) ? '0 : tmr + 1'b1;
            failCnt <= failNxt;
            toErr   <= toErrNxt;
            if (cur == READ_KEY && keyValid)   keyCap  <= keyPass;
            if (cur == READ_LOCK && lockValid) lockCap <= lockPass;
        end
    end

    assign readKey    = (cur == READ_KEY);
    assign readLock   = (cur == READ_LOCK);
    assign unlockDoor = (cur == UNLOCK);
    assign alarm      = (cur == FAIL);
    assign locked     = (cur == LOCKOUT);
    assign timeoutErr = toErr;
    assign failCount  = failCnt;
    assign state      = cur;

endmodule

// File: tb/tb_door_lock_controller.sv
// Scoreboarded bench for door_lock_controller: stimulus predicts events per attempt, a negedge monitor
// measures the DUT's pulses and windows and checks them against the predictions in order.
module tb_door_lock_controller;

    localparam int W  = 32;
    localparam int U  = 8;
    localparam int MF = 3;
    localparam int L  = 16;
    localparam int T  = 10;

    // kind: 0 unlock window, 1 alarm, 2 key timeout, 3 lock timeout, 4 lockout window
    typedef struct {
        int kind;
        int start;
        int width;
        int fc;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         keyReq = 1'b0, keyValid = 1'b0, lockValid = 1'b0;
    logic [W-1:0] keyPass = '0, lockPass = '0;
    logic         readKey, readLock, unlockDoor, alarm, locked, timeoutErr;
    logic [3:0]   failCount;
    logic [2:0]   state;
`ifdef DOOR_LOCK_SENSOR_EN
    logic         doorOpen = 1'b0;
`endif

    door_lock_controller #(.WIDTH(W), .UNLOCK_CYCLES(U), .MAX_FAILS(MF),
                           .LOCKOUT_CYCLES(L), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .keyReq(keyReq), .keyPass(keyPass), .keyValid(keyValid),
        .lockPass(lockPass), .lockValid(lockValid),
`ifdef DOOR_LOCK_SENSOR_EN
        .doorOpen(doorOpen),
`endif
        .readKey(readKey), .readLock(readLock), .unlockDoor(unlockDoor), .alarm(alarm),
        .locked(locked), .timeoutErr(timeoutErr), .failCount(failCount), .state(state)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  checks = 0, errors = 0, pushed = 0, popped = 0;
    int  mFc = 0;
    ev_t expQ[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int start, input int width, input int fc);
        ev_t e;
        e.kind = kind; e.start = start; e.width = width; e.fc = fc;
        expQ.push_back(e);
        pushed++;
    endtask

    task automatic popChk(input int kind, input int start, input int width, input int fc);
        ev_t e;
        if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, start);
            return;
        end
        e = expQ.pop_front();
        popped++;
        chk("event_kind", kind, e.kind);
        chk("event_start", start, e.start);
        chk("event_width", width, e.width);
        chk("event_failCount", fc, e.fc);
    endtask

    // Monitor: measures runs of each output and reports each completed event once.
    int uLen = 0, uStart = 0, uFc = 0, lkLen = 0, lkStart = 0;
    int kRun = 0, lRun = 0, lastRead = 2;
    bit pk = 0, pl = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (readKey) begin kRun = pk ? kRun + 1 : 1; lastRead = 2; end
            if (readLock) begin lRun = pl ? lRun + 1 : 1; lastRead = 3; end
            pk = readKey;
            pl = readLock;
            if (unlockDoor) begin
                if (uLen == 0) begin uStart = cyc; uFc = failCount; end
                uLen++;
            end else if (uLen > 0) begin
                popChk(0, uStart, uLen, uFc);
                uLen = 0;
            end
            if (alarm) popChk(1, cyc, 1, failCount);
            if (timeoutErr) popChk(lastRead, cyc, (lastRead == 2) ? kRun : lRun, failCount);
            if (locked) begin
                if (lkLen == 0) lkStart = cyc;
                lkLen++;
            end else if (lkLen > 0) begin
                popChk(4, lkStart, lkLen, failCount);
                lkLen = 0;
            end
        end
    end

    task automatic waitCyc(input int x);
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One unlock attempt: key valid dk cycles into READ_KEY, lock valid dl cycles into READ_LOCK.
    task automatic attempt(input logic [W-1:0] k, input logic [W-1:0] l, input int dk, input int dl);
        int n, o, done;
        n = cyc;
        keyPass = k; lockPass = l;
        keyReq = 1'b1; keyValid = 1'b0; lockValid = 1'b0;
        o = n + 4 + dk + dl;
        if (dk >= T) begin
            push(2, n + 1 + T, T, mFc);
            done = n + 1 + T;
        end else if (dl >= T) begin
            push(3, n + 2 + dk + T, T, mFc);
            done = n + 2 + dk + T;
        end else if (k == l) begin
            mFc = 0;
            push(0, o, U, 0);
            done = o + U;
        end else begin
            mFc = (mFc == 15) ? 15 : mFc + 1;
            push(1, o, 1, mFc);
            if (mFc >= MF) begin
                push(4, o + 1, L, 0);
                mFc = 0;
                done = o + 1 + L;
            end else done = o + 1;
        end
        waitCyc(n + 1);
        keyReq = 1'b0;
        if (dk < T) begin
            waitCyc(n + 1 + dk);
            keyValid = 1'b1;
            if (dl == 0) lockValid = 1'b1;
            if (dl < T) begin
                waitCyc(n + 2 + dk + dl);
                lockValid = 1'b1;
            end
        end
        // Requests during UNLOCK and LOCKOUT must be ignored.
        if (done == o + U && dk < T && dl < T) begin
            waitCyc(o + 1); keyReq = 1'b1;
            waitCyc(o + 2); keyReq = 1'b0;
        end else if (done == o + 1 + L && dk < T && dl < T) begin
            waitCyc(o + 1 + L / 2); keyReq = 1'b1;
            waitCyc(o + 2 + L / 2); keyReq = 1'b0;
        end
        waitCyc(done);
        keyValid = 1'b0; lockValid = 1'b0;
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_failCount"}, int'(failCount), 0);
        chk({tag, "_outs"}, int'({readKey, readLock, unlockDoor, alarm, locked, timeoutErr}), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 chkIdle("reset");
        @(posedge clk); @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        attempt(32'd20, 32'd45, 0, 0);
        attempt(32'd40, 32'd40, 0, 0);
        attempt(32'd10, 32'd40, 0, 0);
        attempt(32'd40, 32'd70, 0, 0);
        attempt(32'd40, 32'd100, 0, 0);
        attempt(32'd1, 32'd2, 0, 0);
        attempt(32'd3, 32'd4, 0, 0);
        attempt(32'd400, 32'd400, 0, 0);
        attempt(32'd5, 32'd6, 0, 0);
        attempt(32'd7, 32'd8, 0, 0);
        attempt(32'd5, 32'd5, T, 0);
        attempt(32'd5, 32'd5, 0, T);
        attempt(32'd7, 32'd7, T - 1, T - 1);
        attempt(32'hFFFF_FFFF, 32'h7FFF_FFFF, 1, 2);

        // Reset during the third UNLOCK cycle.
        begin
            int n;
            n = cyc;
            keyPass = 32'd40; lockPass = 32'd40; keyReq = 1'b1;
            push(0, n + 4, 2, 0);
            mFc = 0;
            waitCyc(n + 1);
            keyReq = 1'b0; keyValid = 1'b1; lockValid = 1'b1;
            waitCyc(n + 6);
            #1 rst = 1'b1;
            #1 chkIdle("midUnlockReset");
            #1 rst = 1'b0;
            keyValid = 1'b0; lockValid = 1'b0;
            @(posedge clk); #1;
        end
        attempt(32'd40, 32'd40, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] k, l;
            int r, dk, dl;
            k = $urandom;
            l = ($urandom_range(0, 1) == 1) ? k : (k ^ (32'd1 << $urandom_range(0, 31)));
            r = $urandom_range(0, 9);
            dk = (r < 7) ? r % 3 : ((r == 7) ? T - 1 : T);
            r = $urandom_range(0, 9);
            dl = (r < 7) ? r % 3 : ((r == 7) ? T - 1 : T);
            attempt(k, l, dk, dl);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        waitCyc(cyc + 5);
        chk("queue_drained", expQ.size(), 0);
        chk("events_seen", popped, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 50000", cyc);
        $fatal(1);
    end

endmodule
